uart_rcv: RTL and testbench

8-N-1 UART receiver that deserializes an asynchronous serial line into bytes in the system clock domain. It sits between the board's UART RX pin and byte-oriented consumers such as command parsers or FIFOs, and emits each correctly framed byte with a single-cycle valid strobe. The receiver does not apply backpressure and does not report errors; malformed frames and glitches are silently discarded.

---
 rtl/uart_rcv.sv | 160 ++++++++++++++++
 tb/tb_uart_rcv.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rcv.sv
// uart_rcv: 8-N-1 UART receiver.
//
// The asynchronous serial line is synchronized into the clk_in domain and
// framed by a small state machine. Every bit is sampled near its centre.
// A correctly framed byte shows up on data_out together with a single-cycle
// valid_out strobe. Glitches and framing errors produce no output.
//
// Ports:
//   clk_in     system clock
//   rst_in     asynchronous, active-high reset
//   uart_rx    raw serial line (idle high), asynchronous to clk_in
//   valid_out  one-cycle strobe marking a received byte
//   data_out   last received byte, held until the next one arrives
module uart_rcv #(
   parameter int BAUD_RATE   = 115_200,
   parameter int CLOCK_SPEED = 100_000_000
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       uart_rx,
   output logic       valid_out,
   output logic [7:0] data_out
);

   localparam int PERIOD = CLOCK_SPEED / BAUD_RATE;
   localparam int HALF   = PERIOD / 2;
   localparam int CW     = $clog2(PERIOD + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   logic          sync_p0;
   logic          sync_p1;
   logic          rx_s;

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic [2:0]    idx;
   logic [2:0]    idx_n;
   logic [7:0]    shreg;
   logic [7:0]    shreg_n;
   logic          valid_n;
   logic [7:0]    data_n;

   // Synchronizer stage: two flops, reset to the idle (high) level so that
   // leaving reset never looks like a start bit.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         sync_p0 <= uart_rx;
         sync_p1 <= sync_p0;
      end
   end

   assign rx_s = sync_p1;

   // Framing stage: state and datapath registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         valid_out <= 1'b0;
         data_out  <= 8'h00;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         shreg     <= shreg_n;
         valid_out <= valid_n;
         data_out  <= data_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      valid_n = 1'b0;
      data_n  = data_out;

      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               cnt_n   = '0;
            end
         end

         START: begin
            // Any high level during the first half of the start bit is
            // treated as noise rather than the beginning of a frame.
            if (rx_s) begin
               state_n = IDLE;
            end else if (cnt == CNT_HALF) begin
               state_n = DATA;
               cnt_n   = '0;
               idx_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         DATA: begin
            if (cnt == CNT_LAST) begin
               shreg_n[idx] = rx_s;
               cnt_n        = '0;
               idx_n        = idx + 1'b1;
               if (idx == 3'd7) begin
                  state_n = STOP;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_n = '0;
               if (rx_s) begin
                  data_n  = shreg;
                  valid_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n = WAIT_HIGH;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         WAIT_HIGH: begin
            // A low stop bit means a break or a stuck line; hold off until
            // the line returns high so it is not decoded as a byte stream.
            if (rx_s) begin
               state_n = IDLE;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rcv.sv
// tb_uart_rcv: randomized self-checking bench for uart_rcv.
//
// Frames are driven bit by bit on uart_rx. Each well-framed frame queues
// its byte and the clock edge at which the strobe must appear. A monitor on
// the falling edge matches every strobe against that queue and also checks
// that data_out only changes together with a strobe.
module tb_uart_rcv;

   localparam int CLOCK_SPEED = 100_000_000;
   localparam int BAUD_RATE   = 25_000_000;
   localparam int PERIOD      = CLOCK_SPEED / BAUD_RATE;
   localparam int HALF        = PERIOD / 2;
   // Raw pin to strobe: synchronizer plus centre of the stop bit.
   localparam int LAT         = 2 + HALF + 9 * PERIOD;

   logic       clk_in;
   logic       rst_in;
   logic       uart_rx;
   logic       valid_out;
   logic [7:0] data_out;

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   int         pulse_cnt = 0;
   int         pc0;
   logic [7:0] held  = 8'h00;
   logic       prev_v = 1'b0;
   logic [7:0] exp_d [$];
   int         exp_e [$];
   logic [7:0] d;
   int         e;

   uart_rcv #(
      .BAUD_RATE   (BAUD_RATE),
      .CLOCK_SPEED (CLOCK_SPEED)
   ) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .uart_rx   (uart_rx),
      .valid_out (valid_out),
      .data_out  (data_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Strobe monitor and scoreboard.
   always @(negedge clk_in) begin
      if (rst_in) begin
         held   = 8'h00;
         prev_v = 1'b0;
      end else begin
         if (valid_out) begin
            pulse_cnt++;
            check("back_to_back_valid", {31'd0, prev_v}, 32'd0);
            if (exp_d.size() == 0) begin
               check("spurious_valid", 32'd1, 32'd0);
            end else begin
               d = exp_d.pop_front();
               e = exp_e.pop_front();
               check("data", {24'd0, data_out}, {24'd0, d});
               check("latency", cyc, e);
               held = d;
            end
         end else if (exp_e.size() > 0 && cyc > exp_e[0]) begin
            check("missing_valid", cyc, exp_e[0]);
            void'(exp_d.pop_front());
            void'(exp_e.pop_front());
         end
         check("data_hold", {24'd0, data_out}, {24'd0, held});
         prev_v = valid_out;
      end
   end

   // All tasks below start and end one time unit after a rising edge.
   task automatic idle(input int n);
      uart_rx = 1'b1;
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      if (stop) begin
         exp_d.push_back(b);
         exp_e.push_back(cyc + 1 + LAT);
      end
      for (int i = 0; i < 10; i++) begin
         uart_rx = bits[i];
         repeat (PERIOD) @(posedge clk_in);
         #1;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_d.size() != 0; i++) @(posedge clk_in);
      repeat (3) @(posedge clk_in);
      #1;
      check("drain", exp_d.size(), 32'd0);
   endtask

   initial begin
      rst_in  = 1'b1;
      uart_rx = 1'b1;
      #12;
      check("reset_valid", {31'd0, valid_out}, 32'd0);
      check("reset_data", {24'd0, data_out}, 32'd0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      idle(5);

      // Single frame.
      pc0 = pulse_cnt;
      send_frame(8'h9F, 1'b1);
      drain();
      check("single_pulses", pulse_cnt - pc0, 32'd1);

      // One-cycle glitch, then a real frame right after it.
      pc0 = pulse_cnt;
      uart_rx = 1'b0;
      @(posedge clk_in);
      #1;
      uart_rx = 1'b1;
      @(posedge clk_in);
      #1;
      send_frame(8'h9F, 1'b1);
      drain();
      check("glitch_pulses", pulse_cnt - pc0, 32'd1);

      // Framing error with the line held low afterwards.
      pc0 = pulse_cnt;
      send_frame(8'hC3, 1'b0);
      uart_rx = 1'b0;
      repeat (3 * PERIOD) @(posedge clk_in);
      #1;
      check("framing_no_pulse", pulse_cnt - pc0, 32'd0);
      idle(PERIOD);
      send_frame(8'h5A, 1'b1);
      drain();
      check("framing_recover_pulses", pulse_cnt - pc0, 32'd1);

      // Reset during bit 3 of a frame.
      pc0 = pulse_cnt;
      uart_rx = 1'b0;
      repeat (PERIOD) @(posedge clk_in);
      #1;
      for (int i = 0; i < 3; i++) begin
         uart_rx = i[0];
         repeat (PERIOD) @(posedge clk_in);
         #1;
      end
      uart_rx = 1'b1;
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      #1;
      check("midrst_valid", {31'd0, valid_out}, 32'd0);
      check("midrst_data", {24'd0, data_out}, 32'd0);
      repeat (3) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      idle(2 * LAT);
      check("midrst_no_pulse", pulse_cnt - pc0, 32'd0);
      send_frame(8'h3C, 1'b1);
      drain();
      check("after_rst_data", {24'd0, data_out}, 32'h3C);
      check("after_rst_pulses", pulse_cnt - pc0, 32'd1);

      // Back-to-back frames with no idle gap.
      pc0 = pulse_cnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'hA5, 1'b1);
      drain();
      check("b2b_pulses", pulse_cnt - pc0, 32'd3);

      // Random bytes with random idle gaps, some of them zero.
      pc0 = pulse_cnt;
      for (int n = 0; n < 24; n++) begin
         send_frame(8'($urandom_range(0, 255)), 1'b1);
         idle($urandom_range(0, 6));
      end
      drain();
      check("random_pulses", pulse_cnt - pc0, 32'd24);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
